// File: rtl/jt03_snd_mix.sv
// jt03_snd_mix -- output mixer behind the YM2203 FM accumulator.
//
// Removes DC from the unsigned PSG level, applies the Q4.4 per-source gains and
// adds the FM and PSG terms. The result saturates to signed 16 bits. A single
// 16x9 signed multiplier is shared between the two sources by a four-state
// sequencer. The states are IDLE, MUL_FM, MUL_PSG and SUM.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   clk_en     clock enable; nothing advances while low
//   fm_snd     signed 16-bit FM sample
//   fm_sample  new FM sample valid (qualified by clk_en)
//   psg_snd    unsigned 10-bit PSG level
//   psg_en     PSG contributes when high
//   fm_gain    unsigned Q4.4 FM gain (8'h10 = 1.0)
//   psg_gain   unsigned Q4.4 PSG gain
//   snd        signed mixed output, held between updates
//   sample     one-clk_en-cycle strobe when snd updates
//   clip       the sample on snd was saturated
//   overrun    sticky: a pending input was overwritten before use
module jt03_snd_mix #(
    parameter int DCW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [15:0] fm_snd,
    input  logic        fm_sample,
    input  logic [9:0]  psg_snd,
    input  logic        psg_en,
    input  logic [7:0]  fm_gain,
    input  logic [7:0]  psg_gain,
    output logic [15:0] snd,
    output logic        sample,
    output logic        clip,
    output logic        overrun
);

    localparam int AW = DCW + 10;
    localparam logic signed [20:0] SMAX = 21'sd32767;
    localparam logic signed [20:0] SMIN = -21'sd32768;

    typedef enum logic [1:0] {IDLE, MUL_FM, MUL_PSG, SUM} state_t;

    state_t             state;
    logic               pending;

    // Input register: always holds the most recent capture
    logic signed [15:0] in_fm;
    logic [9:0]         in_psg;
    logic               in_psg_en;
    logic [7:0]         in_fm_gain;
    logic [7:0]         in_psg_gain;

    // The PSG fields are copied out of the input register in MUL_FM. A capture
    // arriving mid-operation can then overwrite the input register without
    // corrupting the sample already in flight.
    logic [9:0]         wk_psg;
    logic               wk_psg_en;
    logic [7:0]         wk_psg_gain;

    logic [AW-1:0]      dc_acc;
    logic signed [19:0] fm_term;
    logic signed [19:0] psg_term;

    logic               capture;
    logic [9:0]         dc;
    logic signed [10:0] psg_ac;
    logic [AW-1:0]      dc_acc_next;
    logic signed [15:0] mul_a;
    logic signed [8:0]  mul_b;
    logic signed [24:0] prod;
    logic signed [19:0] mul_term;
    logic signed [20:0] sum;
    logic [15:0]        sat_val;
    logic               sat_hit;

    assign capture = clk_en & fm_sample;

    // DC tracker: dc is the current estimate and is used before the update
    assign dc          = dc_acc[AW-1:DCW];
    assign psg_ac      = $signed({1'b0, wk_psg}) - $signed({1'b0, dc});
    assign dc_acc_next = dc_acc + AW'(wk_psg) - AW'(dc);

    // Shared multiplier: FM sample in MUL_FM, scaled AC PSG in MUL_PSG
    always_comb begin
        mul_a = in_fm;
        mul_b = $signed({1'b0, in_fm_gain});
        if (state == MUL_PSG) begin
            mul_a = {psg_ac, 5'b0_0000};
            mul_b = $signed({1'b0, wk_psg_gain});
        end
    end

    assign prod     = 25'(mul_a) * 25'(mul_b);
    assign mul_term = 20'(prod >>> 4);

    assign sum = {fm_term[19], fm_term} + {psg_term[19], psg_term};

    always_comb begin
        sat_val = sum[15:0];
        sat_hit = 1'b0;
        if (sum > SMAX) begin
            sat_val = 16'h7FFF;
            sat_hit = 1'b1;
        end else if (sum < SMIN) begin
            sat_val = 16'h8000;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= 1'b0;
            in_fm       <= '0;
            in_psg      <= '0;
            in_psg_en   <= 1'b0;
            in_fm_gain  <= '0;
            in_psg_gain <= '0;
            wk_psg      <= '0;
            wk_psg_en   <= 1'b0;
            wk_psg_gain <= '0;
            dc_acc      <= '0;
            fm_term     <= '0;
            psg_term    <= '0;
            snd         <= '0;
            sample      <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // The strobe lasts a single enabled cycle and is low on disabled cycles
            sample <= 1'b0;
            if (clk_en) begin
                if (capture) begin
                    in_fm       <= fm_snd;
                    in_psg      <= psg_snd;
                    in_psg_en   <= psg_en;
                    in_fm_gain  <= fm_gain;
                    in_psg_gain <= psg_gain;
                    if (state != IDLE && pending)
                        overrun <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (capture)
                            state <= MUL_FM;
                    end
                    MUL_FM: begin
                        fm_term     <= mul_term;
                        wk_psg      <= in_psg;
                        wk_psg_en   <= in_psg_en;
                        wk_psg_gain <= in_psg_gain;
                        pending     <= pending | capture;
                        state       <= MUL_PSG;
                    end
                    MUL_PSG: begin
                        psg_term <= wk_psg_en ? mul_term : 20'sd0;
                        dc_acc   <= dc_acc_next;
                        pending  <= pending | capture;
                        state    <= SUM;
                    end
                    default: begin
                        snd    <= sat_val;
                        clip   <= sat_hit;
                        sample <= 1'b1;
                        // A queued sample or a capture on this very cycle goes
                        // straight into the next multiply. If a capture lands
                        // while pending is set, it replaces the queued input.
                        // It is then processed once only.
                        pending <= 1'b0;
                        if (pending || capture)
                            state <= MUL_FM;
                        else
                            state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt03_snd_mix.sv
module tb_jt03_snd_mix;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [15:0] fm_snd;
    logic        fm_sample;
    logic [9:0]  psg_snd;
    logic        psg_en;
    logic [7:0]  fm_gain;
    logic [7:0]  psg_gain;
    logic [15:0] snd;
    logic        sample;
    logic        clip;
    logic        overrun;

    jt03_snd_mix #(.DCW(4)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .fm_snd(fm_snd), .fm_sample(fm_sample),
        .psg_snd(psg_snd), .psg_en(psg_en),
        .fm_gain(fm_gain), .psg_gain(psg_gain),
        .snd(snd), .sample(sample), .clip(clip), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int snd;
        bit clip;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   en_edges = 0;
    int   mdl_dc   = 0;

    // Count the enabled clock edges so the bench can measure latency
    always @(posedge clk) if (!rst && clk_en) en_edges++;

    // Reference mixer. It advances the DC tracker once per processed sample.
    function automatic exp_t model(int fm, int psg, bit en, int fg, int pg, int due);
        exp_t e;
        int ft, dcv, ac, pt, s;
        ft = (fm * fg) >>> 4;
        dcv = mdl_dc / 16;
        ac = psg - dcv;
        pt = en ? ((ac * 32 * pg) >>> 4) : 0;
        mdl_dc = mdl_dc + psg - dcv;
        s = ft + pt;
        e.clip = 1'b0;
        if (s > 32767) begin s = 32767; e.clip = 1'b1; end
        if (s < -32768) begin s = -32768; e.clip = 1'b1; end
        e.snd = s;
        e.due = due;
        return e;
    endfunction

    task automatic cap(input int fm, input int psg, input bit en, input int fg, input int pg,
                       output int edge_idx);
        @(negedge clk);
        fm_snd    = 16'(fm);
        psg_snd   = 10'(psg);
        psg_en    = en;
        fm_gain   = 8'(fg);
        psg_gain  = 8'(pg);
        fm_sample = 1'b1;
        clk_en    = 1'b1;
        edge_idx  = en_edges + 1;
        @(posedge clk);
        #1 fm_sample = 1'b0;
    endtask

    // Wait, within a bounded number of cycles, until a strobe is observed.
    task automatic wait_sample(input int budget, input bit gappy, output bit got, output int at_edge);
        got = 1'b0;
        at_edge = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample) begin
                got = 1'b1;
                at_edge = en_edges;
                break;
            end
            if (gappy) clk_en = ($urandom_range(0, 2) != 0);
        end
        clk_en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 1'b1; fm_sample = 1'b0; fm_snd = '0; psg_snd = '0;
        psg_en = 1'b0; fm_gain = '0; psg_gain = '0;
        repeat (3) @(negedge clk);
        checks++; if (snd !== 16'h0) begin failures++; $display("FAIL reset_snd got=%h exp=0000", snd); end
        checks++; if (sample !== 1'b0) begin failures++; $display("FAIL reset_sample got=%b exp=0", sample); end
        checks++; if (clip !== 1'b0) begin failures++; $display("FAIL reset_clip got=%b exp=0", clip); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        rst = 1'b0;
        $display("test_reset: outputs snd=%h sample=%b clip=%b overrun=%b", snd, sample, clip, overrun);
    endtask

    task automatic test_basic();
        int k, at; bit got; exp_t e;
        cap(1000, 0, 1'b0, 8'h10, 8'h10, k);
        sb.push_back(model(1000, 0, 1'b0, 8'h10, 8'h10, k + 3));
        wait_sample(60, 1'b1, got, at);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++; $display("FAIL basic_timeout got_strobe=%b exp=1", got);
        end else begin
            e = sb.pop_front();
            if (int'($signed(snd)) !== e.snd || clip !== e.clip || at !== e.due) begin
                failures++;
                $display("FAIL basic snd=%0d clip=%b edge=%0d exp snd=%0d clip=%b edge=%0d",
                         $signed(snd), clip, at, e.snd, e.clip, e.due);
            end
            $display("test_basic: snd=%0d clip=%b edge=%0d", $signed(snd), clip, at);
        end
        // Strobe must drop on a disabled cycle and snd must hold
        clk_en = 1'b0;
        @(negedge clk);
        checks++;
        if (sample !== 1'b0 || snd !== 16'd1000) begin
            failures++; $display("FAIL basic_hold sample=%b snd=%0d exp sample=0 snd=1000", sample, $signed(snd));
        end
        clk_en = 1'b1;
    endtask

    // Run a list of isolated samples through the scoreboard
    task automatic run_list(input string name, input int fm[], input int fg[], input int psg, input bit en);
        int k, at; bit got; exp_t e;
        for (int i = 0; i < fm.size(); i++) begin
            cap(fm[i], psg, en, fg[i], 8'h10, k);
            sb.push_back(model(fm[i], psg, en, fg[i], 8'h10, k + 3));
            wait_sample(20, 1'b0, got, at);
            checks++;
            if (!got || sb.size() == 0) begin
                failures++; $display("FAIL %s_timeout idx=%0d got_strobe=%b exp=1", name, i, got);
            end else begin
                e = sb.pop_front();
                if (int'($signed(snd)) !== e.snd || clip !== e.clip || at !== e.due) begin
                    failures++;
                    $display("FAIL %s idx=%0d snd=%0d clip=%b edge=%0d exp snd=%0d clip=%b edge=%0d",
                             name, i, $signed(snd), clip, at, e.snd, e.clip, e.due);
                end
                $display("%s[%0d]: snd=%0d clip=%b", name, i, $signed(snd), clip);
            end
        end
    endtask

    task automatic test_saturation();
        int fm[] = '{20000, -20000, 5};
        int fg[] = '{8'h20, 8'h20, 8'h10};
        run_list("sat", fm, fg, 0, 1'b0);
    endtask

    task automatic test_gain();
        int fm[] = '{-100, -100, 700};
        int fg[] = '{8'h08, 8'h00, 8'hFF};
        run_list("gain", fm, fg, 0, 1'b0);
    endtask

    task automatic test_dc();
        int fm[] = '{0, 0, 0, 0, 0};
        int fg[] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
        run_list("dc", fm, fg, 512, 1'b1);
    endtask

    task automatic test_back_to_back();
        int k1, k2, k3, at; bit got; exp_t e;
        cap(100, 0, 1'b0, 8'h10, 8'h10, k1);
        cap(200, 0, 1'b0, 8'h10, 8'h10, k2);
        cap(300, 0, 1'b0, 8'h10, 8'h10, k3);
        sb.push_back(model(100, 0, 1'b0, 8'h10, 8'h10, k1 + 3));
        sb.push_back(model(300, 0, 1'b0, 8'h10, 8'h10, k1 + 6));
        for (int i = 0; i < 2; i++) begin
            wait_sample(20, 1'b0, got, at);
            checks++;
            if (!got || sb.size() == 0) begin
                failures++; $display("FAIL b2b_timeout idx=%0d got_strobe=%b exp=1", i, got);
            end else begin
                e = sb.pop_front();
                if (int'($signed(snd)) !== e.snd || clip !== e.clip || at !== e.due) begin
                    failures++;
                    $display("FAIL b2b idx=%0d snd=%0d clip=%b edge=%0d exp snd=%0d clip=%b edge=%0d",
                             i, $signed(snd), clip, at, e.snd, e.clip, e.due);
                end
                $display("b2b[%0d]: snd=%0d edge=%0d overrun=%b", i, $signed(snd), at, overrun);
            end
        end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun got=%b exp=1", overrun); end
        wait_sample(10, 1'b0, got, at);
        checks++;
        if (got) begin failures++; $display("FAIL b2b_extra_strobe got=1 exp=0 snd=%0d", $signed(snd)); end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL b2b_overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_reset_mid();
        int k, at; bit got; exp_t e;
        cap(20000, 0, 1'b0, 8'h20, 8'h10, k);
        repeat (3) @(negedge clk);   // FSM now in SUM
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdl_dc = 0;
        checks++; if (snd !== 16'h0) begin failures++; $display("FAIL rstmid_snd got=%h exp=0000", snd); end
        checks++; if (sample !== 1'b0) begin failures++; $display("FAIL rstmid_sample got=%b exp=0", sample); end
        checks++; if (clip !== 1'b0) begin failures++; $display("FAIL rstmid_clip got=%b exp=0", clip); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
        wait_sample(6, 1'b0, got, at);
        checks++;
        if (got) begin failures++; $display("FAIL rstmid_escape got_strobe=1 exp=0 snd=%0d", $signed(snd)); end
        cap(1234, 0, 1'b0, 8'h10, 8'h10, k);
        sb.push_back(model(1234, 0, 1'b0, 8'h10, 8'h10, k + 3));
        wait_sample(20, 1'b0, got, at);
        checks++;
        if (!got || sb.size() == 0) begin
            failures++; $display("FAIL rstmid_after_timeout got_strobe=%b exp=1", got);
        end else begin
            e = sb.pop_front();
            if (int'($signed(snd)) !== e.snd || clip !== e.clip || at !== e.due) begin
                failures++;
                $display("FAIL rstmid_after snd=%0d clip=%b edge=%0d exp snd=%0d clip=%b edge=%0d",
                         $signed(snd), clip, at, e.snd, e.clip, e.due);
            end
            $display("test_reset_mid: after reset snd=%0d edge=%0d", $signed(snd), at);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_gain();
        test_dc();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
